// File: rtl/factorial_bus_master.sv
// Bus initiator that sequences the factorial register target:
// write n, pulse go, poll status, read result, hand it back.
module factorial_bus_master #(
    parameter int POLL_LIMIT = 1024,
    parameter int CNT_W      = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_n,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_error,
    output logic        resp_timeout,
    output logic        bus_we,
    output logic [1:0]  bus_address,
    output logic [3:0]  bus_wdata,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR_N,
        WR_GO,
        SETTLE,
        POLL,
        RD_RES,
        RESP
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]      result_q, result_d;
    logic             error_q, error_d;
    logic             timeout_q, timeout_d;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            n_q       <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        error_d     = error_q;
        timeout_d   = timeout_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        bus_we      = 1'b0;
        bus_address = 2'd2;
        bus_wdata   = 4'd0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    n_d       = req_n;
                    result_d  = '0;
                    error_d   = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = WR_N;
                end
            end
            WR_N: begin
                bus_we      = 1'b1;
                bus_address = 2'd0;
                bus_wdata   = n_q;
                state_d     = WR_GO;
            end
            WR_GO: begin
                bus_we      = 1'b1;
                bus_address = 2'd1;
                bus_wdata   = 4'b0001;
                cnt_d       = '0;
                state_d     = SETTLE;
            end
            // Status from before go may still show done; skip one sample.
            SETTLE: begin
                state_d = POLL;
            end
            POLL: begin
                cnt_d = cnt_inc;
                if (bus_rdata[0]) begin
                    error_d = bus_rdata[1];
                    state_d = RD_RES;
                end else if (cnt_inc == CNT_W'(POLL_LIMIT)) begin
                    timeout_d = 1'b1;
                    result_d  = '0;
                    error_d   = 1'b0;
                    state_d   = RESP;
                end
            end
            RD_RES: begin
                bus_address = 2'd3;
                result_d    = bus_rdata;
                state_d     = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign resp_result  = result_q;
    assign resp_error   = error_q;
    assign resp_timeout = timeout_q;

endmodule
